alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

- Registered decode stage that turns one RV64I integer instruction into ALU operands and a 5-bit operation select per accepted transfer.
- Also produces destination-register write control and an illegal-instruction flag.
- Sits between fetch/register-file read and the execute stage.
- Has one output pipeline register with a valid/ready handshake and a flush input.

## Interface
- DATA_WIDTH, 64, operand/PC width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  instruction available
- in_ready  output  1  stage can accept this cycle
- in_instr  input  32  instruction word
- in_pc  input  DATA_WIDTH  instruction address
- rs1_data  input  DATA_WIDTH  register-file read of in_instr[19:15], valid with in_valid
- rs2_data  input  DATA_WIDTH  register-file read of in_instr[24:20], valid with in_valid
- flush  input  1  discard held and incoming instruction
- out_valid  output  1  decoded entry present
- out_ready  input  1  execute consumes entry
- out_a, out_b  output  DATA_WIDTH  ALU operands
- out_sel  output  5  ALU operation select
- out_rd  output  5  destination register
- out_wen  output  1  register write enable
- out_illegal  output  1  unsupported or malformed encoding
- out_pc  output  DATA_WIDTH  PC of the held instruction

## Operation
- ALU select codes:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7
  - SRL=8, SRA=9, ADDW=10, SUBW=11, SLLW=12, SRLW=13, SRAW=14
- OP (0110011), by funct3/funct7:
  - a=rs1, b=rs2.
  - funct7 0000000 is legal for all funct3.
  - funct7 0100000 is legal only for funct3 000 (SUB) and 101 (SRA).
  - Any other funct7 is illegal.
- OP-IMM (0010011):
  - a=rs1, b=sign-extended I-immediate.
  - No SUB.
  - Shifts use a 6-bit shamt from instr[25:20]; instr[31:26] must be 000000, or 010000 for SRAI, else illegal.
- OP-32 (0111011) and OP-IMM-32 (0011011): word forms ADDW/SUBW/SLLW/SRLW/SRAW plus immediate variants.
  - Word shift immediates require instr[25]=0, else illegal.
  - funct3 values other than 000/001/101 are illegal.
- LUI: sel=ADD, a=0, b=sign-extended {instr[31:12],12'b0}.
- AUIPC: sel=ADD, a=in_pc, b=same U-immediate.
- Any other opcode is illegal.
- Illegal entries: out_illegal=1, out_sel=ADD, out_wen=0, out_a=out_b=0, out_rd still captured.
- out_wen = legal && rd!=0.

## Timing
- Latency: 1 cycle. Input accepted in cycle N appears on outputs in cycle N+1.
- in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
- Transfer on the input side when in_valid && in_ready && !flush. The output register loads and out_valid=1.
- Output consumed when out_valid && out_ready. If no new transfer happens in the same cycle, out_valid=0 next cycle.
- Simultaneous consume and accept: register reloads and out_valid stays 1, so back-to-back throughput is 1/cycle.
- Back-pressure: while out_valid && !out_ready, all outputs are held stable and in_ready=0.
- flush has priority over everything: next cycle out_valid=0, and any instruction offered in the flush cycle is dropped.
- rst has priority over flush. Next cycle, all outputs are 0, including out_valid, out_sel, out_wen, out_illegal and the data buses.
- Reset mid-stall discards the held entry.

## Configuration
- ALU_DECODE_WORD_OPS_EN defined: OP-32 and OP-IMM-32 decode to codes 10–14 as above.
- Not defined: both opcodes are illegal, codes 10–14 are never emitted, and the word-shamt check logic is absent.

## Structure
- Shared package alu_pkg holds:
  - alu_op_e (5-bit enum, codes above)
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32, OPC_LUI, OPC_AUIPC
  - funct7 constants F7_BASE=0000000, F7_ALT=0100000
- Execute stage imports alu_pkg for the same codes.
- One sub-module alu_imm_gen: combinational I/U immediate sign extension to DATA_WIDTH, instantiated once.

## Test plan
- add x3,x1,x2 with rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, sel=0, a=5, b=7, rd=3, wen=1.
- srai x5,x6,63 (instr 0x43F35293), rs1=0x8000_0000_0000_0000 → sel=9, b=63, illegal=0. Same with instr[26] set → illegal=1, wen=0.
- auipc x1,0x80000 at pc=0x1000 → sel=0, a=0x1000, b=0xFFFF_FFFF_8000_0000.
- Stream 3 back-to-back legal instructions with out_ready=0 for 2 cycles on the first → first held stable, in_ready=0, none lost or duplicated, order preserved.
- flush asserted while out_valid=1 and in_valid=1 → next cycle out_valid=0, the offered instruction never appears.
- sraiw x2,x2,3, macro defined → sel=14, b=3. Macro undefined → illegal=1, sel=0, wen=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU operation codes and RV64I decode constants, used by decode and execute.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLT  = 5'd5,
    ALU_SLTU = 5'd6,
    ALU_SLL  = 5'd7,
    ALU_SRL  = 5'd8,
    ALU_SRA  = 5'd9,
    ALU_ADDW = 5'd10,
    ALU_SUBW = 5'd11,
    ALU_SLLW = 5'd12,
    ALU_SRLW = 5'd13,
    ALU_SRAW = 5'd14
  } alu_op_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct3 meaning shared by OP and OP-IMM when funct7 selects the base variant
  function automatic alu_op_e baseOp(input logic [2:0] funct3);
    case (funct3)
      3'b000:  baseOp = ALU_ADD;
      3'b001:  baseOp = ALU_SLL;
      3'b010:  baseOp = ALU_SLT;
      3'b011:  baseOp = ALU_SLTU;
      3'b100:  baseOp = ALU_XOR;
      3'b101:  baseOp = ALU_SRL;
      3'b110:  baseOp = ALU_OR;
      default: baseOp = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Handshake bundle between fetch/regfile read, the decode stage and execute.
interface alu_decode_stage_if #(parameter int DATA_WIDTH = 64);

  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_a;
  logic [DATA_WIDTH-1:0] out_b;
  logic [4:0]            out_sel;
  logic [4:0]            out_rd;
  logic                  out_wen;
  logic                  out_illegal;
  logic [DATA_WIDTH-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_sel, out_rd, out_wen, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, out_a, out_b, out_sel, out_rd, out_wen, out_illegal, out_pc
  );

endinterface

// File: rtl/alu_imm_gen.sv
// Sign-extends the RV I-type and U-type immediates to the datapath width.
module alu_imm_gen #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [19:0]           instrHi_i,
  output logic [DATA_WIDTH-1:0] immI_o,
  output logic [DATA_WIDTH-1:0] immU_o
);

  assign immI_o = {{(DATA_WIDTH-12){instrHi_i[19]}}, instrHi_i[19:8]};
  assign immU_o = {{(DATA_WIDTH-32){instrHi_i[19]}}, instrHi_i, 12'h000};

endmodule

// File: rtl/alu_decode_stage.sv
// RV64I decode stage: one registered entry of ALU operands/select with valid/ready and flush.
// Define ALU_DECODE_WORD_OPS_EN to decode OP-32/OP-IMM-32 word forms; otherwise they are illegal.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input logic              clk,
  input logic              rst,
  alu_decode_stage_if.slave bus
);

  logic [31:0]           instr;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [DATA_WIDTH-1:0] immI;
  logic [DATA_WIDTH-1:0] immU;
  logic [DATA_WIDTH-1:0] shamt6;
`ifdef ALU_DECODE_WORD_OPS_EN
  logic [DATA_WIDTH-1:0] shamt5;
`endif

  logic                  legal;
  alu_op_e               sel;
  logic [DATA_WIDTH-1:0] opA;
  logic [DATA_WIDTH-1:0] opB;

  logic                  accept;
  logic                  valid_d, valid_q;
  logic [DATA_WIDTH-1:0] a_d, a_q, b_d, b_q, pc_d, pc_q;
  logic [4:0]            sel_d, sel_q, rd_d, rd_q;
  logic                  wen_d, wen_q, illegal_d, illegal_q;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign shamt6 = {{(DATA_WIDTH-6){1'b0}}, instr[25:20]};
`ifdef ALU_DECODE_WORD_OPS_EN
  assign shamt5 = {{(DATA_WIDTH-5){1'b0}}, instr[24:20]};
`endif

  alu_imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
    .instrHi_i (instr[31:12]),
    .immI_o    (immI),
    .immU_o    (immU)
  );

  // Anything not matched as legal collapses to an inert ADD of zeros
  always_comb begin
    legal = 1'b0;
    sel   = ALU_ADD;
    opA   = bus.rs1_data;
    opB   = bus.rs2_data;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          sel   = baseOp(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          legal = 1'b1;
          sel   = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          legal = 1'b1;
          sel   = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        opB = immI;
        case (funct3)
          3'b001: begin
            legal = (instr[31:26] == 6'b000000);
            sel   = ALU_SLL;
            opB   = shamt6;
          end
          3'b101: begin
            legal = (instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000);
            sel   = instr[30] ? ALU_SRA : ALU_SRL;
            opB   = shamt6;
          end
          default: begin
            legal = 1'b1;
            sel   = baseOp(funct3);
          end
        endcase
      end
`ifdef ALU_DECODE_WORD_OPS_EN
      OPC_OP_32: begin
        case (funct3)
          3'b000: begin
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            sel   = (funct7 == F7_ALT) ? ALU_SUBW : ALU_ADDW;
          end
          3'b001: begin
            legal = (funct7 == F7_BASE);
            sel   = ALU_SLLW;
          end
          3'b101: begin
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            sel   = (funct7 == F7_ALT) ? ALU_SRAW : ALU_SRLW;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM_32: begin
        opB = immI;
        case (funct3)
          3'b000: begin
            legal = 1'b1;
            sel   = ALU_ADDW;
          end
          3'b001: begin
            legal = (funct7 == F7_BASE);
            sel   = ALU_SLLW;
            opB   = shamt5;
          end
          3'b101: begin
            legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            sel   = (funct7 == F7_ALT) ? ALU_SRAW : ALU_SRLW;
            opB   = shamt5;
          end
          default: legal = 1'b0;
        endcase
      end
`endif
      OPC_LUI: begin
        legal = 1'b1;
        opA   = '0;
        opB   = immU;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        opA   = bus.in_pc;
        opB   = immU;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      sel = ALU_ADD;
      opA = '0;
      opB = '0;
    end
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

  always_comb begin
    a_d       = opA;
    b_d       = opB;
    sel_d     = sel;
    rd_d      = instr[11:7];
    wen_d     = legal && (instr[11:7] != 5'd0);
    illegal_d = !legal;
    pc_d      = bus.in_pc;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Payload only moves on an accepted transfer, so a stalled entry stays frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      illegal_q <= 1'b0;
      pc_q      <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        a_q       <= a_d;
        b_q       <= b_d;
        sel_q     <= sel_d;
        rd_q      <= rd_d;
        wen_q     <= wen_d;
        illegal_q <= illegal_d;
        pc_q      <= pc_d;
      end
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_a       = a_q;
  assign bus.out_b       = b_q;
  assign bus.out_sel     = sel_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_wen     = wen_q;
  assign bus.out_illegal = illegal_q;
  assign bus.out_pc      = pc_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: mask/match instruction model plus directed vectors.
module tb_alu_decode_stage;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] pc;
    logic [4:0]  sel;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
  } entry_t;

  // Operand source kinds: 0 rs1/rs2, 1 rs1/I-imm, 2 rs1/shamt, 3 zero/U-imm, 4 pc/U-imm
  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [4:0]  sel;
    logic [2:0]  kind;
  } pat_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] pc;
    logic [63:0] expA;
    logic [63:0] expB;
    logic [4:0]  expSel;
    logic        expIll;
    logic        expWen;
  } vec_t;

  logic clk;
  logic rst;

  alu_decode_stage_if #(.DATA_WIDTH(64)) bus ();

  alu_decode_stage #(.DATA_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     vectors    = 0;
  int     miscompares = 0;
  pat_t   pats[$];
  vec_t   vecs[$];
  logic [63:0] consumedPc[$];
  entry_t exp;
  logic   expValid  = 1'b0;
  logic   expZero   = 1'b0;
  logic   modelKnown = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic addPat(input logic [31:0] mask, input logic [31:0] match,
                        input logic [4:0] sel, input logic [2:0] kind);
    pat_t p;
    p.mask = mask; p.match = match; p.sel = sel; p.kind = kind;
    pats.push_back(p);
  endtask

  task automatic addVec(input logic [31:0] instr, input logic [63:0] rs1, input logic [63:0] pc,
                        input logic [63:0] expA, input logic [63:0] expB, input logic [4:0] expSel,
                        input logic expIll, input logic expWen);
    vec_t v;
    v.instr = instr; v.rs1 = rs1; v.pc = pc; v.expA = expA; v.expB = expB;
    v.expSel = expSel; v.expIll = expIll; v.expWen = expWen;
    vecs.push_back(v);
  endtask

  function automatic entry_t decodeModel(input logic [31:0] instr, input logic [63:0] pc,
                                         input logic [63:0] rs1, input logic [63:0] rs2);
    entry_t e;
    logic [63:0] immI, immU, shamt;
    immI  = {{52{instr[31]}}, instr[31:20]};
    immU  = {{32{instr[31]}}, instr[31:12], 12'h000};
    shamt = {58'd0, instr[25:20]};
    e = '0;
    e.pc = pc;
    e.rd = instr[11:7];
    e.illegal = 1'b1;
    foreach (pats[i]) begin
      if (e.illegal && ((instr & pats[i].mask) == pats[i].match)) begin
        e.illegal = 1'b0;
        e.sel = pats[i].sel;
        e.wen = (instr[11:7] != 5'd0);
        case (pats[i].kind)
          3'd0:    begin e.a = rs1; e.b = rs2;   end
          3'd1:    begin e.a = rs1; e.b = immI;  end
          3'd2:    begin e.a = rs1; e.b = shamt; end
          3'd3:    begin e.a = '0;  e.b = immU;  end
          default: begin e.a = pc;  e.b = immU;  end
        endcase
      end
    end
    return e;
  endfunction

  // Reference pipeline register: compare every cycle, then advance on the upcoming edge's inputs
  always @(negedge clk) begin
    if (modelKnown) begin
      checkOutput("out_valid", 64'(bus.out_valid), 64'(expValid));
      checkOutput("in_ready", 64'(bus.in_ready), 64'(!expValid || bus.out_ready));
      if (expValid || expZero) begin
        checkOutput("out_a", bus.out_a, exp.a);
        checkOutput("out_b", bus.out_b, exp.b);
        checkOutput("out_sel", 64'(bus.out_sel), 64'(exp.sel));
        checkOutput("out_rd", 64'(bus.out_rd), 64'(exp.rd));
        checkOutput("out_wen", 64'(bus.out_wen), 64'(exp.wen));
        checkOutput("out_illegal", 64'(bus.out_illegal), 64'(exp.illegal));
        checkOutput("out_pc", bus.out_pc, exp.pc);
      end
      if (bus.out_valid && bus.out_ready && !rst) consumedPc.push_back(bus.out_pc);
    end
    if (rst) begin
      exp        = '0;
      expValid   = 1'b0;
      expZero    = 1'b1;
      modelKnown = 1'b1;
    end else if (modelKnown) begin
      if (bus.flush) begin
        expValid = 1'b0;
      end else if (bus.in_valid && (!expValid || bus.out_ready)) begin
        exp      = decodeModel(bus.in_instr, bus.in_pc, bus.rs1_data, bus.rs2_data);
        expValid = 1'b1;
        expZero  = 1'b0;
      end else if (bus.out_ready) begin
        expValid = 1'b0;
      end
    end
  end

  // Drives one cycle of inputs and returns just after the edge that samples them
  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [63:0] pc,
                               input logic [63:0] rs1, input logic [63:0] rs2,
                               input logic outReady, input logic flushIn, input logic rstIn);
    bus.in_valid  = valid;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.rs1_data  = rs1;
    bus.rs2_data  = rs2;
    bus.out_ready = outReady;
    bus.flush     = flushIn;
    rst           = rstIn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    entry_t m;
    addPat(32'hFE00707F, 32'h00000033, 5'd0, 3'd0);
    addPat(32'hFE00707F, 32'h40000033, 5'd1, 3'd0);
    addPat(32'hFE00707F, 32'h00001033, 5'd7, 3'd0);
    addPat(32'hFE00707F, 32'h00002033, 5'd5, 3'd0);
    addPat(32'hFE00707F, 32'h00003033, 5'd6, 3'd0);
    addPat(32'hFE00707F, 32'h00004033, 5'd4, 3'd0);
    addPat(32'hFE00707F, 32'h00005033, 5'd8, 3'd0);
    addPat(32'hFE00707F, 32'h40005033, 5'd9, 3'd0);
    addPat(32'hFE00707F, 32'h00006033, 5'd3, 3'd0);
    addPat(32'hFE00707F, 32'h00007033, 5'd2, 3'd0);
    addPat(32'h0000707F, 32'h00000013, 5'd0, 3'd1);
    addPat(32'h0000707F, 32'h00002013, 5'd5, 3'd1);
    addPat(32'h0000707F, 32'h00003013, 5'd6, 3'd1);
    addPat(32'h0000707F, 32'h00004013, 5'd4, 3'd1);
    addPat(32'h0000707F, 32'h00006013, 5'd3, 3'd1);
    addPat(32'h0000707F, 32'h00007013, 5'd2, 3'd1);
    addPat(32'hFC00707F, 32'h00001013, 5'd7, 3'd2);
    addPat(32'hFC00707F, 32'h00005013, 5'd8, 3'd2);
    addPat(32'hFC00707F, 32'h40005013, 5'd9, 3'd2);
    addPat(32'h0000007F, 32'h00000037, 5'd0, 3'd3);
    addPat(32'h0000007F, 32'h00000017, 5'd0, 3'd4);
`ifdef ALU_DECODE_WORD_OPS_EN
    addPat(32'hFE00707F, 32'h0000003B, 5'd10, 3'd0);
    addPat(32'hFE00707F, 32'h4000003B, 5'd11, 3'd0);
    addPat(32'hFE00707F, 32'h0000103B, 5'd12, 3'd0);
    addPat(32'hFE00707F, 32'h0000503B, 5'd13, 3'd0);
    addPat(32'hFE00707F, 32'h4000503B, 5'd14, 3'd0);
    addPat(32'h0000707F, 32'h0000001B, 5'd10, 3'd1);
    addPat(32'hFE00707F, 32'h0000101B, 5'd12, 3'd2);
    addPat(32'hFE00707F, 32'h0000501B, 5'd13, 3'd2);
    addPat(32'hFE00707F, 32'h4000501B, 5'd14, 3'd2);
`endif

    addVec(32'h002081B3, 64'd5, 64'h1000, 64'd5, 64'd7, 5'd0, 1'b0, 1'b1);
    addVec(32'h40208233, 64'd5, 64'h1000, 64'd5, 64'd7, 5'd1, 1'b0, 1'b1);
    addVec(32'h02208233, 64'd5, 64'h1000, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    addVec(32'h40209233, 64'd5, 64'h1000, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    addVec(32'h43F35293, 64'h8000000000000000, 64'h1000, 64'h8000000000000000, 64'd63, 5'd9, 1'b0, 1'b1);
    addVec(32'h47F35293, 64'h8000000000000000, 64'h1000, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    addVec(32'h80000097, 64'd5, 64'h1000, 64'h1000, 64'hFFFFFFFF80000000, 5'd0, 1'b0, 1'b1);
    addVec(32'h123452B7, 64'd5, 64'h1000, 64'd0, 64'h12345000, 5'd0, 1'b0, 1'b1);
    addVec(32'hFFF00093, 64'd5, 64'h1000, 64'd5, 64'hFFFFFFFFFFFFFFFF, 5'd0, 1'b0, 1'b1);
    addVec(32'h03F09093, 64'd5, 64'h1000, 64'd5, 64'd63, 5'd7, 1'b0, 1'b1);
    addVec(32'h0000A083, 64'd5, 64'h1000, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    addVec(32'h0050B093, 64'd5, 64'h1000, 64'd5, 64'd5, 5'd6, 1'b0, 1'b1);
`ifdef ALU_DECODE_WORD_OPS_EN
    addVec(32'h4031511B, 64'd5, 64'h1000, 64'd5, 64'd3, 5'd14, 1'b0, 1'b1);
    addVec(32'h003100BB, 64'd5, 64'h1000, 64'd5, 64'd7, 5'd10, 1'b0, 1'b1);
`else
    addVec(32'h4031511B, 64'd5, 64'h1000, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    addVec(32'h003100BB, 64'd5, 64'h1000, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
`endif
    addVec(32'h003120BB, 64'd5, 64'h1000, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    addVec(32'h0210909B, 64'd5, 64'h1000, 64'd0, 64'd0, 5'd0, 1'b1, 1'b0);
    addVec(32'h00000013, 64'd5, 64'h1000, 64'd5, 64'd0, 5'd0, 1'b0, 1'b0);

    m = decodeModel(32'h43F35293, 64'h0, 64'h8000000000000000, 64'd7);
    checkOutput("model srai sel", 64'(m.sel), 64'd9);
    checkOutput("model srai b", m.b, 64'd63);
    m = decodeModel(32'h80000097, 64'h1000, 64'd0, 64'd0);
    checkOutput("model auipc b", m.b, 64'hFFFFFFFF80000000);
    checkOutput("model auipc a", m.a, 64'h1000);

    $display("[TB] reset");
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset out_sel", 64'(bus.out_sel), 64'd0);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);

    $display("[TB] directed vectors back-to-back");
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].rs1, 64'd7, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d valid", i), 64'(bus.out_valid), 64'd1);
      checkOutput($sformatf("vec%0d sel", i), 64'(bus.out_sel), 64'(vecs[i].expSel));
      checkOutput($sformatf("vec%0d illegal", i), 64'(bus.out_illegal), 64'(vecs[i].expIll));
      checkOutput($sformatf("vec%0d wen", i), 64'(bus.out_wen), 64'(vecs[i].expWen));
      checkOutput($sformatf("vec%0d a", i), bus.out_a, vecs[i].expA);
      checkOutput($sformatf("vec%0d b", i), bus.out_b, vecs[i].expB);
    end
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);

    $display("[TB] stream with back-pressure");
    consumedPc.delete();
    applyStimulus(1'b1, 32'h002081B3, 64'h100, 64'd1, 64'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40208233, 64'h104, 64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
    checkOutput("stall pc", bus.out_pc, 64'h100);
    checkOutput("stall in_ready", 64'(bus.in_ready), 64'd0);
    applyStimulus(1'b1, 32'h40208233, 64'h104, 64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
    checkOutput("stall2 pc", bus.out_pc, 64'h100);
    applyStimulus(1'b1, 32'h40208233, 64'h104, 64'd3, 64'd4, 1'b1, 1'b0, 1'b0);
    checkOutput("release pc", bus.out_pc, 64'h104);
    applyStimulus(1'b1, 32'h0050B093, 64'h108, 64'd5, 64'd6, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("stream count", 64'(consumedPc.size()), 64'd3);
    if (consumedPc.size() == 3) begin
      checkOutput("stream order0", consumedPc[0], 64'h100);
      checkOutput("stream order1", consumedPc[1], 64'h104);
      checkOutput("stream order2", consumedPc[2], 64'h108);
    end

    $display("[TB] flush");
    consumedPc.delete();
    applyStimulus(1'b1, 32'h002081B3, 64'h200, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40208233, 64'hDEAD0, 64'd3, 64'd4, 1'b0, 1'b1, 1'b0);
    checkOutput("flush out_valid", 64'(bus.out_valid), 64'd0);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("flush dropped", 64'(consumedPc.size()), 64'd0);

    $display("[TB] reset during stall");
    applyStimulus(1'b1, 32'h123452B7, 64'h300, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h002081B3, 64'h304, 64'd1, 64'd2, 1'b0, 1'b1, 1'b1);
    checkOutput("rst out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst out_b", bus.out_b, 64'd0);
    checkOutput("rst out_pc", bus.out_pc, 64'd0);
    checkOutput("rst out_wen", 64'(bus.out_wen), 64'd0);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
